// File: rtl/dut_seq_pkg.sv
// Shared types and constants for the dut start sequencer.
// States, the state_out width, default parameters, the per-state output
// decode and a counter-width helper.
package dut_seq_pkg;

    localparam int STATE_W = 3;

    localparam int DEF_LOCK_STABLE_CYCLES = 256;
    localparam int DEF_RESET_HOLD_CYCLES  = 16;
    localparam int DEF_START_PULSE_CYCLES = 1;
    localparam int DEF_GRACE_CYCLES       = 8;
    localparam int DEF_CNT_W              = 16;
    localparam int DEF_HB_DIV             = 24;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD_RST  = 3'd2,
        ST_START     = 3'd3,
        ST_RUN       = 3'd4,
        ST_STOP      = 3'd5
    } seq_state_t;

    // Control lines driven toward the dut, one bit each.
    typedef struct packed {
        logic dut_reset;
        logic clock_en;
        logic start;
        logic stop;
        logic running;
    } seq_outs_t;

    // Width for a counter that must hold values 0..max_val without wrapping.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Output levels for each state. The dut is held in reset everywhere
    // except START and RUN.
    function automatic seq_outs_t state_outs(input seq_state_t s);
        seq_outs_t o;
        o.dut_reset = 1'b1;
        o.clock_en  = 1'b0;
        o.start     = 1'b0;
        o.stop      = 1'b0;
        o.running   = 1'b0;
        case (s)
            ST_HOLD_RST: o.clock_en = 1'b1;
            ST_START: begin
                o.dut_reset = 1'b0;
                o.clock_en  = 1'b1;
                o.start     = 1'b1;
            end
            ST_RUN: begin
                o.dut_reset = 1'b0;
                o.clock_en  = 1'b1;
                o.running   = 1'b1;
            end
            ST_STOP: o.stop = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dut_seq_lock_sync.sv
// Two-flop synchroniser for the asynchronous MMCM LOCKED signal.
// Both flops clear on the synchronous reset.
module dut_seq_lock_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    (* ASYNC_REG = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE" *) logic r_sync;

    // Shift the asynchronous level through two flops placed together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/dut_start_sequencer.sv
// Start sequencer for the LFSR dut: qualifies MMCM lock, then walks the dut
// through reset hold, start pulse and run, counting qualified fail cycles.
// Optional heartbeat LED behaviour is enabled with DUT_SEQ_HEARTBEAT_EN.
module dut_start_sequencer
    import dut_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int START_PULSE_CYCLES = DEF_START_PULSE_CYCLES,
    parameter int GRACE_CYCLES       = DEF_GRACE_CYCLES,
    parameter int CNT_W              = DEF_CNT_W,
    parameter int HB_DIV             = DEF_HB_DIV
) (
    input  logic               ref_clk_in,
    input  logic               reset,
    input  logic               mmcm_locked_in,
    input  logic               pass_in,
    output logic               dut_reset_out,
    output logic               clock_en_out,
    output logic               start_out,
    output logic               stop_out,
    output logic               running_out,
    output logic               fail_sticky_out,
    output logic [CNT_W-1:0]   fail_count_out,
    output logic [STATE_W-1:0] state_out,
    output logic               led_out
);

    // Each counter stops at its last value, so none can wrap.
    localparam int SW = cnt_w(LOCK_STABLE_CYCLES - 1);
    localparam int HW = cnt_w(RESET_HOLD_CYCLES - 1);
    localparam int PW = cnt_w(START_PULSE_CYCLES - 1);
    localparam int GW = cnt_w(GRACE_CYCLES);

    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [PW-1:0] START_LAST  = PW'(START_PULSE_CYCLES - 1);
    localparam logic [GW-1:0] GRACE_LAST  = GW'(GRACE_CYCLES);

    logic       w_lock_s;
    seq_state_t w_next_state;
    logic       w_fail_qual;

    seq_state_t       r_state;
    seq_outs_t        r_outs;
    logic [SW-1:0]    r_stable_cnt;
    logic [HW-1:0]    r_hold_cnt;
    logic [PW-1:0]    r_start_cnt;
    logic [GW-1:0]    r_grace_cnt;
    logic             r_fail_sticky;
    logic [CNT_W-1:0] r_fail_count;

    dut_seq_lock_sync u_lock_sync (
        .i_clk   (ref_clk_in),
        .i_rst   (reset),
        .i_async (mmcm_locked_in),
        .o_sync  (w_lock_s)
    );

    // Next-state decode; losing lock in any dut-active state forces STOP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      w_next_state = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (w_lock_s && (r_stable_cnt == STABLE_LAST))
                    w_next_state = ST_HOLD_RST;
            end
            ST_HOLD_RST: begin
                if (!w_lock_s)
                    w_next_state = ST_STOP;
                else if (r_hold_cnt == HOLD_LAST)
                    w_next_state = ST_START;
            end
            ST_START: begin
                if (!w_lock_s)
                    w_next_state = ST_STOP;
                else if (r_start_cnt == START_LAST)
                    w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (!w_lock_s)
                    w_next_state = ST_STOP;
            end
            ST_STOP:      w_next_state = ST_WAIT_LOCK;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // A fail counts only in RUN, past the grace window, with lock still good.
    assign w_fail_qual = (r_state == ST_RUN) && w_lock_s &&
                         (r_grace_cnt == GRACE_LAST) && !pass_in;

    // State, per-state counters, registered outputs and fail tracking.
    always_ff @(posedge ref_clk_in) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_outs        <= state_outs(ST_IDLE);
            r_stable_cnt  <= '0;
            r_hold_cnt    <= '0;
            r_start_cnt   <= '0;
            r_grace_cnt   <= '0;
            r_fail_sticky <= 1'b0;
            r_fail_count  <= '0;
        end else begin
            r_state <= w_next_state;
            r_outs  <= state_outs(w_next_state);

            if ((r_state == ST_WAIT_LOCK) && w_lock_s && (r_stable_cnt != STABLE_LAST))
                r_stable_cnt <= r_stable_cnt + 1'b1;
            else
                r_stable_cnt <= '0;

            if ((r_state == ST_HOLD_RST) && (r_hold_cnt != HOLD_LAST))
                r_hold_cnt <= r_hold_cnt + 1'b1;
            else
                r_hold_cnt <= '0;

            if ((r_state == ST_START) && (r_start_cnt != START_LAST))
                r_start_cnt <= r_start_cnt + 1'b1;
            else
                r_start_cnt <= '0;

            if (r_state == ST_RUN) begin
                if (r_grace_cnt != GRACE_LAST)
                    r_grace_cnt <= r_grace_cnt + 1'b1;
            end else begin
                r_grace_cnt <= '0;
            end

            if (w_fail_qual) begin
                r_fail_sticky <= 1'b1;
                if (r_fail_count != {CNT_W{1'b1}})
                    r_fail_count <= r_fail_count + 1'b1;
            end
        end
    end

`ifdef DUT_SEQ_HEARTBEAT_EN
    logic [HB_DIV-1:0] r_hb_cnt;
    logic              r_hb_phase;
    logic              r_led;
    logic              w_hb_phase_next;
    logic              w_sticky_next;

    // Phase restarts high on every RUN entry and flips once per 2^HB_DIV run cycles.
    assign w_hb_phase_next = (r_state == ST_RUN) ? (r_hb_phase ^ (&r_hb_cnt)) : 1'b1;
    assign w_sticky_next   = r_fail_sticky | w_fail_qual;

    // Heartbeat divider and LED register; a latched fail pins the LED on.
    always_ff @(posedge ref_clk_in) begin
        if (reset) begin
            r_hb_cnt   <= '0;
            r_hb_phase <= 1'b1;
            r_led      <= 1'b0;
        end else begin
            r_hb_cnt   <= (r_state == ST_RUN) ? r_hb_cnt + 1'b1 : '0;
            r_hb_phase <= w_hb_phase_next;
            if (w_sticky_next)
                r_led <= 1'b1;
            else
                r_led <= (w_next_state == ST_RUN) && w_hb_phase_next;
        end
    end

    assign led_out = r_led;
`else
    assign led_out = r_outs.running;
`endif

    assign dut_reset_out   = r_outs.dut_reset;
    assign clock_en_out    = r_outs.clock_en;
    assign start_out       = r_outs.start;
    assign stop_out        = r_outs.stop;
    assign running_out     = r_outs.running;
    assign fail_sticky_out = r_fail_sticky;
    assign fail_count_out  = r_fail_count;
    assign state_out       = r_state;

endmodule

// File: tb/tb_dut_start_sequencer.sv
// Self-checking bench for dut_start_sequencer: cycle model plus directed
// literal checkpoints through start, fail counting, lock loss, flicker and reset.
module tb_dut_start_sequencer;

    localparam int LK = 4;
    localparam int RH = 3;
    localparam int SP = 2;
    localparam int GR = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          mmcm;
    logic          pass;
    logic          dut_reset_out, clock_en_out, start_out, stop_out, running_out;
    logic          fail_sticky_out, led_out;
    logic [CW-1:0] fail_count_out;
    logic [2:0]    state_out;

    int checks   = 0;
    int failures = 0;

    dut_start_sequencer #(
        .LOCK_STABLE_CYCLES (LK),
        .RESET_HOLD_CYCLES  (RH),
        .START_PULSE_CYCLES (SP),
        .GRACE_CYCLES       (GR),
        .CNT_W              (CW),
        .HB_DIV             (3)
    ) dut (
        .ref_clk_in      (clk),
        .reset           (reset),
        .mmcm_locked_in  (mmcm),
        .pass_in         (pass),
        .dut_reset_out   (dut_reset_out),
        .clock_en_out    (clock_en_out),
        .start_out       (start_out),
        .stop_out        (stop_out),
        .running_out     (running_out),
        .fail_sticky_out (fail_sticky_out),
        .fail_count_out  (fail_count_out),
        .state_out       (state_out),
        .led_out         (led_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Output levels by phase: idle, wait, hold, start, run, stop.
    bit exp_rst [6] = '{1, 1, 1, 0, 0, 1};
    bit exp_ce  [6] = '{0, 0, 1, 1, 1, 0};
    bit exp_st  [6] = '{0, 0, 0, 1, 0, 0};
    bit exp_sp  [6] = '{0, 0, 0, 0, 0, 1};
    bit exp_run [6] = '{0, 0, 0, 0, 1, 0};

    int m_state = 0;
    int m_age   = 0;   // cycles already spent in the current phase
    int m_cons  = 0;   // consecutive lock_s=1 samples while waiting
    int m_fail  = 0;
    bit m_sticky = 0;
    bit m_s0 = 0, m_s1 = 0;
    bit m_valid = 0;

    always @(posedge clk) begin : model_p
        int nxt;
        bit ls;
        if (reset) begin
            m_state = 0; m_age = 0; m_cons = 0; m_fail = 0; m_sticky = 0;
            m_s0 = 0; m_s1 = 0; m_valid = 1;
        end else if (m_valid) begin
            ls  = m_s1;
            nxt = m_state;
            case (m_state)
                0: nxt = 1;
                1: begin
                    m_cons = ls ? m_cons + 1 : 0;
                    if (m_cons == LK) nxt = 2;
                end
                2: if (!ls) nxt = 5; else if (m_age + 1 == RH) nxt = 3;
                3: if (!ls) nxt = 5; else if (m_age + 1 == SP) nxt = 4;
                4: begin
                    if (!ls) nxt = 5;
                    else if (m_age >= GR && !pass) begin
                        m_sticky = 1;
                        if (m_fail < (1 << CW) - 1) m_fail++;
                    end
                end
                default: nxt = 1;
            endcase
            if (nxt == 1 && m_state != 1) m_cons = 0;
            m_age   = (nxt == m_state) ? m_age + 1 : 0;
            m_state = nxt;
            m_s1 = m_s0;
            m_s0 = mmcm;
        end
    end

    // Every cycle after the first reset edge the DUT must match the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_state",     state_out,       m_state);
            chk("m_dut_reset", dut_reset_out,   exp_rst[m_state]);
            chk("m_clock_en",  clock_en_out,    exp_ce[m_state]);
            chk("m_start",     start_out,       exp_st[m_state]);
            chk("m_stop",      stop_out,        exp_sp[m_state]);
            chk("m_running",   running_out,     exp_run[m_state]);
            chk("m_sticky",    fail_sticky_out, m_sticky);
            chk("m_fail_cnt",  fail_count_out,  m_fail);
`ifndef DUT_SEQ_HEARTBEAT_EN
            chk("m_led",       led_out,         exp_run[m_state]);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    bit flick [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        reset = 1'b1; mmcm = 1'b1; pass = 1'b1;
        cyc(2);
        chk("rst_state",     state_out, 0);
        chk("rst_dut_reset", dut_reset_out, 1);
        chk("rst_clock_en",  clock_en_out, 0);
        chk("rst_fail_cnt",  fail_count_out, 0);
        reset = 1'b0;

        // Clean start: wait lock, 4 qualified samples, hold 3, start 2, run.
        cyc(1);
        chk("cs_wait", state_out, 1);
        cyc(5);
        chk("cs_hold_state", state_out, 2);
        chk("cs_hold_rst",   dut_reset_out, 1);
        chk("cs_hold_ce",    clock_en_out, 1);
        cyc(2);
        chk("cs_hold_last", state_out, 2);
        cyc(1);
        chk("cs_start",     start_out, 1);
        chk("cs_start_rst", dut_reset_out, 0);
        cyc(1);
        chk("cs_start2",    start_out, 1);
        cyc(1);
        chk("cs_run",       running_out, 1);
        chk("cs_run_start", start_out, 0);

        // Fail counting from RUN entry: two grace cycles, then saturate.
        pass = 1'b0;
        cyc(5);
        chk("fc_after5", fail_count_out, 3);
        chk("fc_sticky", fail_sticky_out, 1);
        cyc(15);
        chk("fc_sat", fail_count_out, 15);
        pass = 1'b1;
        cyc(2);

        // Lock loss in RUN: two sync cycles, then STOP for one cycle.
        mmcm = 1'b0;
        cyc(2);
        chk("ll_still_run", state_out, 4);
        cyc(1);
        chk("ll_stop",      state_out, 5);
        chk("ll_stop_out",  stop_out, 1);
        chk("ll_stop_ce",   clock_en_out, 0);
        cyc(1);
        chk("ll_wait",      state_out, 1);
        chk("ll_stop_gone", stop_out, 0);
        chk("ll_cnt_kept",  fail_count_out, 15);
        cyc(3);

        // Flicker while waiting: the drop restarts the qualification count.
        for (int k = 0; k < 8; k++) begin
            mmcm = flick[k];
            cyc(1);
            chk("fl_wait", state_out, 1);
        end
        mmcm = 1'b1;
        cyc(1);
        chk("fl_wait_last", state_out, 1);
        cyc(1);
        chk("fl_hold",      state_out, 2);
        chk("fl_hold_cnt",  fail_count_out, 15);

        // Reset in HOLD_RST: straight back to reset values, no stop pulse.
        reset = 1'b1;
        cyc(1);
        chk("rh_state",     state_out, 0);
        chk("rh_stop",      stop_out, 0);
        chk("rh_dut_reset", dut_reset_out, 1);
        chk("rh_clock_en",  clock_en_out, 0);
        chk("rh_fail_cnt",  fail_count_out, 0);
        chk("rh_sticky",    fail_sticky_out, 0);
        reset = 1'b0;

        // Re-lock repeats the full sequence.
        cyc(6);
        chk("rl_hold",  state_out, 2);
        cyc(3);
        chk("rl_start", state_out, 3);
        cyc(2);
        chk("rl_run",   running_out, 1);
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dut_start_sequencer.md
Name: dut_start_sequencer

Overview:
- Control stage directly upstream of the LFSR dut core. Sits between the MMCM lock indicator and the dut control inputs.
- Synchronises and qualifies the MMCM lock, then sequences dut reset, clock enable, start and stop.
- Monitors the dut pass flag during the run and keeps a sticky fail flag plus a saturating fail-cycle count for gpio/LED.
- Replaces the raw lock-to-reset/start wiring at FPGA top level.

Parameters:
- LOCK_STABLE_CYCLES, 256: consecutive synchronised-lock cycles required before sequencing starts (min 1).
- RESET_HOLD_CYCLES, 16: cycles the dut reset is held with clock enable active (min 1).
- START_PULSE_CYCLES, 1: width of the start_out pulse (min 1).
- GRACE_CYCLES, 8: cycles after entering RUN during which pass_in is ignored.
- CNT_W, 16: fail counter width.
- HB_DIV, 24: heartbeat divider exponent (used only with the optional feature).

Ports:
- ref_clk_in  in  1  sole clock (MMCM output via BUFG)
- reset  in  1  synchronous, active-high reset
- mmcm_locked_in  in  1  MMCM LOCKED; asynchronous, 2-FF synchronised internally
- pass_in  in  1  dut pass_out
- dut_reset_out  out  1  to dut reset
- clock_en_out  out  1  to dut clock_en_in
- start_out  out  1  to dut start_in
- stop_out  out  1  to dut stop_in
- running_out  out  1  high in RUN
- fail_sticky_out  out  1  set on first qualified fail, cleared only by reset
- fail_count_out  out  CNT_W  saturating count of qualified fail cycles
- state_out  out  3  current state encoding
- led_out  out  1  status LED

Behaviour:
- Clocking and reset: one clock, ref_clk_in. Reset is synchronous and active-high.
- Reset values while reset=1 and on the cycle after: state=IDLE, dut_reset_out=1, clock_en_out=0, start_out=0, stop_out=0, running_out=0, fail_sticky_out=0, fail_count_out=0, led_out=0. The lock synchroniser flops clear to 0.
- Outputs: all outputs are registered, updated on the same edge as the state register.
- Lock synchronisation: lock_s = mmcm_locked_in delayed by 2 flops, so 2-cycle latency.
- State encoding: IDLE=0, WAIT_LOCK=1, HOLD_RST=2, START=3, RUN=4, STOP=5.
- IDLE: dut_reset_out=1, clock_en_out=0. Goes to WAIT_LOCK unconditionally on the next edge.
- WAIT_LOCK:
  - Outputs as IDLE.
  - Stable counter increments on each lock_s=1 and clears to 0 on lock_s=0.
  - Goes to HOLD_RST on the edge that samples the LOCK_STABLE_CYCLES-th consecutive lock_s=1.
- HOLD_RST:
  - dut_reset_out=1, clock_en_out=1, so the dut's synchronous reset takes effect.
  - Lasts exactly RESET_HOLD_CYCLES cycles, then START.
- START:
  - dut_reset_out=0, clock_en_out=1, start_out=1.
  - Lasts exactly START_PULSE_CYCLES cycles, then RUN.
- RUN:
  - clock_en_out=1, running_out=1, start_out=0.
  - Grace counter starts at 0 on entry.
  - Once the grace counter reaches GRACE_CYCLES, every cycle with pass_in=0 is a qualified fail: fail_count_out increments, saturating at 2^CNT_W-1, and fail_sticky_out is set.
- Lock loss: lock_s=0 sampled in HOLD_RST, START or RUN goes to STOP on the next edge. Lock loss in RUN takes priority over fail counting on that cycle.
- STOP:
  - Exactly 1 cycle: stop_out=1, clock_en_out=0, dut_reset_out=1, running_out=0.
  - Then WAIT_LOCK with the stable counter cleared.
  - fail_count_out and fail_sticky_out persist across STOP.
- Counter sizing: stable, hold, start and grace counters are sized with $clog2 of their max and never wrap; each clears on state entry.
- Reset mid-operation: reset has priority over everything and returns the block to IDLE within 1 cycle. No stop_out pulse is emitted.
- Flicker: lock_s flickering during WAIT_LOCK restarts the stable count on every 0.

Optional Feature:
- Macro: DUT_SEQ_HEARTBEAT_EN.
- Defined: led_out toggles every 2^HB_DIV cycles while in RUN, is held at 1 when fail_sticky_out=1, and is 0 otherwise.
- Undefined: led_out = running_out, and the heartbeat counter is not instantiated.

Decomposition:
- Shared package dut_seq_pkg holds:
  - the state typedef and its encodings (IDLE..STOP);
  - the state_out width constant of 3;
  - default parameter constants.
- One natural sub-module: dut_seq_lock_sync (2-FF synchroniser with ASYNC_REG attributes).
- FSM and counters stay in the top module.

Test Plan:
- Parameters for all scenarios: LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=3, START_PULSE_CYCLES=2, GRACE_CYCLES=2, CNT_W=4.
- Clean start: reset 2 cycles, lock high from cycle 0 -> lock_s high at +2, HOLD_RST 4 cycles later, dut_reset_out high with clock_en_out=1 for 3 cycles, start_out high 2 cycles, then running_out=1.
- Lock flicker: lock 1,1,1,0,1,1,1,1 in WAIT_LOCK -> no HOLD_RST until the 4th consecutive 1 after the drop; state_out stays 1 throughout.
- Fail counting: in RUN, pass_in=0 for 20 cycles starting at RUN entry -> first 2 ignored, fail_count_out saturates at 15, fail_sticky_out=1.
- Lock loss in RUN: drop lock -> 2 cycles later STOP, stop_out=1 exactly one cycle, then WAIT_LOCK. fail_count_out is retained. Re-lock repeats the full sequence.
- Reset mid-HOLD_RST: assert reset -> next cycle all outputs at reset values, fail_count_out=0, no stop_out pulse.
- DUT_SEQ_HEARTBEAT_EN defined with HB_DIV=3: in RUN, led_out toggles every 8 cycles. Undefined: led_out mirrors running_out.
